// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS-subset datapath (lw/sw/R-type/beq/ori/addiu/j).
// Outputs decode from the current state plus opcode/funct; zero gating lives outside this block.
module multicycle_ctrl #(
  parameter logic [2:0] OP_ADD = 3'b000,
  parameter logic [2:0] OP_SUB = 3'b001,
  parameter logic [2:0] OP_AND = 3'b010,
  parameter logic [2:0] OP_OR  = 3'b011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRExec  = 4'd6,
    StRWb    = 4'd7,
    StBranch = 4'd8,
    StIExec  = 4'd9,
    StIWb    = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpcLw    = 6'b100011;
  localparam logic [5:0] OpcSw    = 6'b101011;
  localparam logic [5:0] OpcRType = 6'b000000;
  localparam logic [5:0] OpcBeq   = 6'b000100;
  localparam logic [5:0] OpcOri   = 6'b001101;
  localparam logic [5:0] OpcAddiu = 6'b001001;
  localparam logic [5:0] OpcJ     = 6'b000010;

  state_e state_q, state_d, state_eff;

  // The branch outcome is resolved by the external zero gate, not here.
  logic unused_zero;
  assign unused_zero = zero;

  // R-type funct decode shared by REXEC (ALUOp) and RWB (write enable).
  logic [2:0] r_aluop;
  logic       funct_ok;
  always_comb begin
    r_aluop  = OP_ADD;
    funct_ok = 1'b1;
    case (funct)
      6'b100000, 6'b100001: r_aluop = OP_ADD;
      6'b100010, 6'b100011: r_aluop = OP_SUB;
      6'b100100:            r_aluop = OP_AND;
      6'b100101:            r_aluop = OP_OR;
      default:              funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpcLw, OpcSw:     state_d = StMemAdr;
          OpcRType:         state_d = StRExec;
          OpcBeq:           state_d = StBranch;
          OpcOri, OpcAddiu: state_d = StIExec;
          OpcJ:             state_d = StJump;
          default:          state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (opcode == OpcSw) ? StMemWr : StMemRd;
      StMemRd:  state_d = StMemWb;
      StRExec:  state_d = StRWb;
      StIExec:  state_d = StIWb;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // While in reset every output shows FETCH values, with the FETCH strobes masked.
  assign state_eff = rst ? StFetch : state_q;
  assign state     = state_eff;

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ExtOp       = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUOp       = OP_ADD;
    PCSource    = 2'd0;
    case (state_eff)
      StFetch: begin
        IRWrite = ~rst;
        PCWrite = ~rst;
        ALUSrcB = 2'd1;
      end
      StDecode: begin
        ALUSrcB = 2'd3;
        ExtOp   = 1'b1;
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ExtOp   = 1'b1;
      end
      StMemRd: IorD = 1'b1;
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      StRExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = r_aluop;
      end
      StRWb: begin
        RegDst   = 1'b1;
        RegWrite = funct_ok;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = OP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
      end
      StIExec: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ExtOp   = (opcode != OpcOri);
        ALUOp   = (opcode == OpcOri) ? OP_OR : OP_ADD;
      end
      StIWb: begin
        RegWrite = 1'b1;
        ExtOp    = (opcode != OpcOri);
        ALUOp    = (opcode == OpcOri) ? OP_OR : OP_ADD;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected output sequences checked every cycle,
// with random instruction streams and random reset injection, plus literal spot checks.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ExtOp, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ExtOp      (ExtOp),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .state      (state)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [20:0] got, exp_vec;
  logic        exp_valid = 1'b0;
  logic [20:0] q[$];
  logic [5:0]  next_op, next_fn;

  assign got = {state, PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
                RegWrite, ExtOp, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  function automatic logic [20:0] v(input logic [3:0] st, input logic pcw, input logic pcwc,
                                    input logic iord, input logic memw, input logic irw,
                                    input logic rdst, input logic m2r, input logic rw,
                                    input logic ext, input logic sa, input logic [1:0] sb,
                                    input logic [2:0] op, input logic [1:0] ps);
    return {st, pcw, pcwc, iord, memw, irw, rdst, m2r, rw, ext, sa, sb, op, ps};
  endfunction

  // Expected output sequence of one whole instruction, starting at its FETCH cycle.
  task automatic build(input logic [5:0] op, input logic [5:0] fn);
    logic [2:0] ralu;
    logic       rok;
    rok  = (fn[5:3] == 3'b100) && (fn[2:0] <= 3'd5);
    ralu = !rok ? 3'd0 : (fn[2:0] <= 3'd1) ? 3'd0 : (fn[2:0] <= 3'd3) ? 3'd1
         : (fn[2:0] == 3'd4) ? 3'd2 : 3'd3;
    q.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0));
    case (op)
      6'b100011: begin
        q.push_back(v(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0));
        q.push_back(v(3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(v(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      end
      6'b101011: begin
        q.push_back(v(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0));
        q.push_back(v(5, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      6'b000000: begin
        q.push_back(v(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ralu, 0));
        q.push_back(v(7, 0, 0, 0, 0, 0, 1, 0, rok, 0, 0, 0, 0, 0));
      end
      6'b000100: q.push_back(v(8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
      6'b001101: begin
        q.push_back(v(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0));
        q.push_back(v(10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0));
      end
      6'b001001: begin
        q.push_back(v(9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0));
        q.push_back(v(10, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      end
      6'b000010: q.push_back(v(11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
      default: ;
    endcase
  endtask

  // Drive one cycle; opcode/funct only change when a new instruction is fetched.
  task automatic cycle(input logic r);
    @(posedge clk);
    #1;
    rst  = r;
    zero = 1'($urandom_range(0, 1));
    if (r) begin
      opcode = 6'($urandom);
      funct  = 6'($urandom);
      q.delete();
      exp_vec = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    end else begin
      if (q.size() == 0) begin
        opcode = next_op;
        funct  = next_fn;
        build(next_op, next_fn);
      end
      exp_vec = q.pop_front();
    end
    exp_valid = 1'b1;
    #2;
  endtask

  task automatic lit(input string name, input logic [31:0] g, input logic [31:0] e);
    n_cmp++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, g, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      n_cmp++;
      if (got !== exp_vec) begin
        n_fail++;
        $display("FAIL cycle: got %06h expected %06h (state %0d op %b fn %b rst %b t=%0t)",
                 got, exp_vec, state, opcode, funct, rst, $time);
      end
    end
  end

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 8))
      0: return 6'b100011;
      1: return 6'b101011;
      2, 3: return 6'b000000;
      4: return 6'b000100;
      5: return 6'b001101;
      6: return 6'b001001;
      7: return 6'b000010;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] pick_fn();
    if ($urandom_range(0, 3) == 0) return 6'($urandom);
    return 6'b100000 + 6'($urandom_range(0, 5));
  endfunction

  initial begin
    rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
    next_op = 6'd0; next_fn = 6'd0;

    cycle(1);
    lit("rst_state", state, 0);
    lit("rst_irwrite", IRWrite, 0);
    lit("rst_pcwrite", PCWrite, 0);
    lit("rst_alusrcb", ALUSrcB, 1);

    next_op = 6'b100011; next_fn = 6'd0;
    for (int i = 0; i < 5; i++) begin
      cycle(0);
      lit("lw_state", state, i);
      lit("lw_regwrite", RegWrite, (i == 4) ? 1 : 0);
      lit("lw_memtoreg", MemtoReg, (i == 4) ? 1 : 0);
    end

    next_op = 6'b000000; next_fn = 6'b100010;
    for (int i = 0; i < 4; i++) cycle(0);
    lit("sub_rwb_state", state, 7);
    lit("sub_rwb_regwrite", RegWrite, 1);
    lit("sub_rwb_regdst", RegDst, 1);

    next_fn = 6'b111111;
    for (int i = 0; i < 3; i++) cycle(0);
    lit("badfn_rexec_aluop", ALUOp, 0);
    cycle(0);
    lit("badfn_rwb_regwrite", RegWrite, 0);

    next_op = 6'b000100;
    for (int i = 0; i < 3; i++) cycle(0);
    lit("beq_state", state, 8);
    lit("beq_aluop", ALUOp, 1);
    lit("beq_pcwritecond", PCWriteCond, 1);
    lit("beq_pcsource", PCSource, 1);

    next_op = 6'b001101;
    for (int i = 0; i < 3; i++) cycle(0);
    lit("ori_aluop", ALUOp, 3);
    lit("ori_extop", ExtOp, 0);
    lit("ori_alusrcb", ALUSrcB, 2);
    cycle(0);
    lit("ori_iwb_regwrite", RegWrite, 1);
    lit("ori_iwb_regdst", RegDst, 0);

    next_op = 6'b111111;
    cycle(0);
    cycle(0);
    lit("bad_decode_state", state, 1);
    lit("bad_decode_strobes", {PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite}, 0);
    next_op = 6'b100011;
    cycle(0);
    lit("bad_back_to_fetch", state, 0);

    // Reset landing in MEMRD of a lw.
    for (int i = 0; i < 3; i++) cycle(0);
    lit("midrst_pre_state", state, 3);
    cycle(1);
    lit("midrst_strobes", {MemWrite, RegWrite, PCWrite, IRWrite}, 0);
    cycle(0);
    lit("midrst_state", state, 0);
    lit("midrst_irwrite", IRWrite, 1);
    lit("midrst_pcwrite", PCWrite, 1);

    for (int i = 0; i < 1500; i++) begin
      if (q.size() == 0) begin
        next_op = pick_op();
        next_fn = pick_fn();
      end
      cycle(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
    end

    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter OP_ADD, default 3'b000, meaning ALUOp code for add.
REQ-002 SHALL have parameter OP_SUB, default 3'b001, meaning ALUOp code for subtract.
REQ-003 SHALL have parameter OP_AND, default 3'b010, meaning ALUOp code for bitwise and.
REQ-004 SHALL have parameter OP_OR, default 3'b011, meaning ALUOp code for bitwise or.
REQ-005 SHALL have ports as follows; one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- opcode  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag, current cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if zero
- IorD  output  1  memory address select: 0 = PC, 1 = ALU result register
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- RegDst  output  1  write register select: 1 = rd, 0 = rt
- MemtoReg  output  1  write-data select: 1 = MDR, 0 = ALU result register
- RegWrite  output  1  register file write strobe
- ExtOp  output  1  immediate extend: 1 = sign, 0 = zero
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  0 = B, 1 = constant 4, 2 = extended immediate, 3 = extended immediate << 2
- ALUOp  output  3  operation code to ALU
- PCSource  output  2  0 = ALU, 1 = ALU result register, 2 = jump target
- state  output  4  current FSM state, for debug

Function
REQ-006 SHALL be a Moore FSM. All outputs SHALL be decoded from state, opcode and funct only, except PCWrite/PCWriteCond gating by zero, which happens outside this block.
REQ-007 SHALL use these state encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, RWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11.
REQ-008 FETCH: IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=OP_ADD, PCSource=0, PCWrite=1. Next state is always DECODE.
REQ-009 DECODE: ALUSrcA=0, ALUSrcB=3, ExtOp=1, ALUOp=OP_ADD (branch target).
REQ-010 DECODE next state by opcode:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 -> REXEC
- 000100 (beq) -> BRANCH
- 001101 (ori) or 001001 (addiu) -> IEXEC
- 000010 (j) -> JUMP
- any other opcode -> FETCH, with no write strobe asserted
REQ-011 MEMADR: ALUSrcA=1, ALUSrcB=2, ExtOp=1, ALUOp=OP_ADD. Next state is MEMRD for lw, MEMWR for sw.
REQ-012 MEMRD: IorD=1. Next state MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state FETCH.
REQ-013 MEMWR: IorD=1, MemWrite=1. Next state FETCH.
REQ-014 REXEC: ALUSrcA=1, ALUSrcB=0. ALUOp by funct:
- 100000/100001 -> ADD
- 100010/100011 -> SUB
- 100100 -> AND
- 100101 -> OR
- any other funct -> ADD
Next state RWB.
REQ-015 RWB: RegDst=1, MemtoReg=0. RegWrite=1 only for the six supported functs; otherwise 0. Next state FETCH.
REQ-016 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=OP_SUB, PCWriteCond=1, PCSource=1. Next state FETCH.
REQ-017 IEXEC: ALUSrcA=1, ALUSrcB=2. For ori: ExtOp=0, ALUOp=OP_OR. For addiu: ExtOp=1, ALUOp=OP_ADD. Next state IWB.
REQ-018 IWB: RegDst=0, MemtoReg=0, RegWrite=1. ExtOp/ALUOp SHALL be held as in IEXEC. Next state FETCH.
REQ-019 JUMP: PCWrite=1, PCSource=2. Next state FETCH.
REQ-020 Every output not listed for a state SHALL be 0, including ALUOp=OP_ADD.
REQ-021 At most one of PCWrite, MemWrite, RegWrite, IRWrite SHALL be high in any cycle, except FETCH, where IRWrite and PCWrite are both high.
REQ-022 Cycles per instruction: lw 5; sw, R-type, addiu, ori 4; beq, j 3; unsupported opcode 2.

Reset
REQ-023 When rst=1 at a rising edge, state SHALL become FETCH, regardless of the current state, including mid-instruction.
REQ-024 While rst is high, all write strobes (PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite) SHALL be forced to 0. All other outputs SHALL take their FETCH values.
REQ-025 The first FETCH after rst falls SHALL assert IRWrite and PCWrite.

Verification
REQ-026 Reset, then opcode=100011 held -> state sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4.
REQ-027 opcode=000000, funct=100010 -> state 6 has ALUOp=001; state 7 has RegWrite=1, RegDst=1. With funct=111111: ALUOp=000 and RegWrite=0 in state 7.
REQ-028 opcode=000100 -> sequence 0,1,8,0. State 8 has ALUOp=001, PCWriteCond=1, PCSource=1.
REQ-029 opcode=001101 -> state 9 has ALUOp=011, ExtOp=0, ALUSrcB=2. State 10 has RegWrite=1, RegDst=0.
REQ-030 opcode=111111 -> sequence 0,1,0, with no strobe high in state 1.
REQ-031 rst asserted in state 3 (lw) -> next state 0, with MemWrite, RegWrite, PCWrite and IRWrite held at 0 while rst is high.
